// File: rtl/bram_result_checker_if.sv
// Read-only BRAM port pair (result + golden) seen by bram_result_checker.
// master: the checker drives address/enable/write strobes and samples DOUT.
// slave : the BRAM side (or a bench model) returns DOUT.
interface bram_result_checker_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   BRAM_RES_ADDR;
  logic                BRAM_RES_EN;
  logic [DATA_W/8-1:0] BRAM_RES_WE;
  logic [DATA_W-1:0]   BRAM_RES_DIN;
  logic [DATA_W-1:0]   BRAM_RES_DOUT;
  logic [ADDR_W-1:0]   BRAM_GOLD_ADDR;
  logic                BRAM_GOLD_EN;
  logic [DATA_W/8-1:0] BRAM_GOLD_WE;
  logic [DATA_W-1:0]   BRAM_GOLD_DIN;
  logic [DATA_W-1:0]   BRAM_GOLD_DOUT;

  modport master (
    output BRAM_RES_ADDR, BRAM_RES_EN, BRAM_RES_WE, BRAM_RES_DIN,
    output BRAM_GOLD_ADDR, BRAM_GOLD_EN, BRAM_GOLD_WE, BRAM_GOLD_DIN,
    input  BRAM_RES_DOUT, BRAM_GOLD_DOUT
  );

  modport slave (
    input  BRAM_RES_ADDR, BRAM_RES_EN, BRAM_RES_WE, BRAM_RES_DIN,
    input  BRAM_GOLD_ADDR, BRAM_GOLD_EN, BRAM_GOLD_WE, BRAM_GOLD_DIN,
    output BRAM_RES_DOUT, BRAM_GOLD_DOUT
  );
endinterface

// File: rtl/bram_result_checker.sv
// bram_result_checker: on-chip golden compare of a result BRAM against a
// golden BRAM. After start, NUM_WORDS words are read from both memories in
// lock-step (one per cycle), compared in a pipeline aligned to the BRAM read
// latency, and mismatches are counted (saturating) with the first one held.
// Optional feature macro: MISMATCH_LOG_EN adds a LOG_DEPTH-entry FIFO of
// {index, result word} per mismatch (LOG_DEPTH must be a power of 2, >= 2).
// Start-to-done latency is NUM_WORDS + RD_LAT + 1 cycles.
module bram_result_checker #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 32,
  parameter int                 NUM_WORDS = 294,
  parameter logic [ADDR_W-1:0]  RES_BASE  = '0,
  parameter logic [ADDR_W-1:0]  GOLD_BASE = '0,
  parameter int                 ADDR_INC  = 4,
  parameter int                 RD_LAT    = 1,
  parameter int                 ERR_W     = 16,
  parameter int                 LOG_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [15:0]           first_err_idx,
  output logic [DATA_W-1:0]     first_err_got,
  output logic [DATA_W-1:0]     first_err_exp,
  bram_result_checker_if.master bram,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic [15:0]           log_idx,
  output logic [DATA_W-1:0]     log_got
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
  localparam logic [15:0] NO_ERR   = 16'hFFFF;

  function automatic logic [ERR_W-1:0] f_sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic                r_en;
  logic [15:0]         r_rd_idx;
  logic [ADDR_W-1:0]   r_res_addr;
  logic [ADDR_W-1:0]   r_gold_addr;

  logic [RD_LAT-1:0]   r_vld_p0;
  logic [15:0]         r_idx_p0 [RD_LAT];
  logic                r_vld_p1;
  logic                r_mis_p1;
  logic [15:0]         r_idx_p1;
  logic [DATA_W-1:0]   r_got_p1;
  logic [DATA_W-1:0]   r_exp_p1;

  logic [ERR_W-1:0]    r_err_cnt;
  logic [15:0]         r_first_idx;
  logic [DATA_W-1:0]   r_first_got;
  logic [DATA_W-1:0]   r_first_exp;

  logic                w_start_acc;
  logic                w_mis;
  logic [ERR_W-1:0]    w_err_nxt;
  logic                w_last_retire;

  assign w_start_acc   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_mis         = r_vld_p1 && r_mis_p1;
  assign w_err_nxt     = w_mis ? f_sat_inc(r_err_cnt) : r_err_cnt;
  // The last word is retiring when nothing else is left in the read pipe.
  assign w_last_retire = (r_state == S_DRAIN) && r_vld_p1 && (r_vld_p0 == '0);

  // Run control: issue NUM_WORDS reads, drain, then hold done until restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_en        <= 1'b0;
      r_rd_idx    <= '0;
      r_res_addr  <= '0;
      r_gold_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_acc) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_en        <= 1'b1;
            r_rd_idx    <= '0;
            r_res_addr  <= RES_BASE;
            r_gold_addr <= GOLD_BASE;
          end
        end
        S_RUN: begin
          if (r_rd_idx == LAST_IDX) begin
            r_state <= S_DRAIN;
            r_en    <= 1'b0;
          end else begin
            r_rd_idx    <= r_rd_idx + 16'd1;
            r_res_addr  <= r_res_addr + ADDR_W'(ADDR_INC);
            r_gold_addr <= r_gold_addr + ADDR_W'(ADDR_INC);
          end
        end
        S_DRAIN: begin
          if (w_last_retire) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: valid shift register tracking reads in flight inside the BRAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p0 <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p0[0] <= r_en;
      for (int k = 1; k < RD_LAT; k++) r_vld_p0[k] <= r_vld_p0[k-1];
      r_vld_p1 <= r_vld_p0[RD_LAT-1];
    end
  end

  // Stage p0 -> p1: index alignment and registered word compare.
  always_ff @(posedge clk) begin
    r_idx_p0[0] <= r_rd_idx;
    for (int k = 1; k < RD_LAT; k++) r_idx_p0[k] <= r_idx_p0[k-1];
    r_idx_p1 <= r_idx_p0[RD_LAT-1];
    r_got_p1 <= bram.BRAM_RES_DOUT;
    r_exp_p1 <= bram.BRAM_GOLD_DOUT;
    r_mis_p1 <= (bram.BRAM_RES_DOUT != bram.BRAM_GOLD_DOUT);
  end

  // Stage p1 -> result: saturating error count and first-mismatch capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt   <= '0;
      r_first_idx <= NO_ERR;
      r_first_got <= '0;
      r_first_exp <= '0;
    end else if (w_start_acc) begin
      r_err_cnt   <= '0;
      r_first_idx <= NO_ERR;
      r_first_got <= '0;
      r_first_exp <= '0;
    end else if (w_mis) begin
      r_err_cnt <= w_err_nxt;
      if (r_first_idx == NO_ERR) begin
        r_first_idx <= r_idx_p1;
        r_first_got <= r_got_p1;
        r_first_exp <= r_exp_p1;
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_cnt       = r_err_cnt;
  assign first_err_idx = r_first_idx;
  assign first_err_got = r_first_got;
  assign first_err_exp = r_first_exp;

  assign bram.BRAM_RES_ADDR  = r_res_addr;
  assign bram.BRAM_RES_EN    = r_en;
  assign bram.BRAM_RES_WE    = '0;
  assign bram.BRAM_RES_DIN   = '0;
  assign bram.BRAM_GOLD_ADDR = r_gold_addr;
  assign bram.BRAM_GOLD_EN   = r_en;
  assign bram.BRAM_GOLD_WE   = '0;
  assign bram.BRAM_GOLD_DIN  = '0;

`ifdef MISMATCH_LOG_EN
  localparam int LOG_AW = $clog2(LOG_DEPTH);

  logic [LOG_AW:0]     r_wr_ptr;
  logic [LOG_AW:0]     r_rd_ptr;
  logic [15:0]         r_log_idx_mem [LOG_DEPTH];
  logic [DATA_W-1:0]   r_log_got_mem [LOG_DEPTH];
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[LOG_AW] != r_rd_ptr[LOG_AW]) &&
                   (r_wr_ptr[LOG_AW-1:0] == r_rd_ptr[LOG_AW-1:0]);
  assign w_pop   = !w_empty && log_ready;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign w_push  = w_mis && (!w_full || w_pop);

  // Log pointers; cleared on every accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_start_acc) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Log storage write.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_log_idx_mem[r_wr_ptr[LOG_AW-1:0]] <= r_idx_p1;
      r_log_got_mem[r_wr_ptr[LOG_AW-1:0]] <= r_got_p1;
    end
  end

  assign log_valid = !w_empty;
  assign log_idx   = r_log_idx_mem[r_rd_ptr[LOG_AW-1:0]];
  assign log_got   = r_log_got_mem[r_rd_ptr[LOG_AW-1:0]];
`else
  logic w_unused_log_ready;
  assign w_unused_log_ready = log_ready;
  assign log_valid = 1'b0;
  assign log_idx   = '0;
  assign log_got   = '0;
`endif

endmodule

// File: tb/tb_bram_result_checker.sv
// Bench for bram_result_checker: two instances (RD_LAT=1/ERR_W=16 and
// RD_LAT=2/ERR_W=4) fed by behavioural BRAM models. Expected run results
// come from a reference compare over the bench memories and are queued
// when a run is launched, then popped when the DUT reports done.
module tb_bram_result_checker;
  localparam int          N   = 294;
  localparam logic [31:0] RBA = 32'h0000_0000;
  localparam logic [31:0] GBA = 32'h0000_0400;
  localparam logic [31:0] RBB = 32'h0000_1000;
  localparam logic [31:0] GBB = 32'h0000_2000;

  typedef struct {
    int          err;
    int          idx;
    logic [31:0] got;
    logic [31:0] exp;
    bit          pass;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, startA, startB, log_readyA, log_readyB;
  logic busyA, doneA, passA, busyB, doneB, passB;
  logic [15:0] errA, idxA, idxB, log_idxA, log_idxB;
  logic [3:0]  errB;
  logic [31:0] gotA, expA, gotB, expB, log_gotA, log_gotB;
  logic log_validA, log_validB;

  bram_result_checker_if #(.DATA_W(32), .ADDR_W(32)) ifA ();
  bram_result_checker_if #(.DATA_W(32), .ADDR_W(32)) ifB ();

  bram_result_checker #(.NUM_WORDS(N), .RES_BASE(RBA), .GOLD_BASE(GBA),
                        .RD_LAT(1), .ERR_W(16), .LOG_DEPTH(8)) dutA (
    .clk(clk), .rst(rst), .start(startA), .busy(busyA), .done(doneA), .pass(passA),
    .err_cnt(errA), .first_err_idx(idxA), .first_err_got(gotA), .first_err_exp(expA),
    .bram(ifA), .log_valid(log_validA), .log_ready(log_readyA),
    .log_idx(log_idxA), .log_got(log_gotA));

  bram_result_checker #(.NUM_WORDS(N), .RES_BASE(RBB), .GOLD_BASE(GBB),
                        .RD_LAT(2), .ERR_W(4), .LOG_DEPTH(8)) dutB (
    .clk(clk), .rst(rst), .start(startB), .busy(busyB), .done(doneB), .pass(passB),
    .err_cnt(errB), .first_err_idx(idxB), .first_err_got(gotB), .first_err_exp(expB),
    .bram(ifB), .log_valid(log_validB), .log_ready(log_readyB),
    .log_idx(log_idxB), .log_got(log_gotB));

  logic [31:0] resA [512];
  logic [31:0] goldA[512];
  logic [31:0] resB [512];
  logic [31:0] goldB[512];
  logic [31:0] qRB, qGB;

  // One-cycle-latency BRAM pair for instance A.
  always @(posedge clk) begin
    if (ifA.BRAM_RES_EN)  ifA.BRAM_RES_DOUT  <= resA[9'((ifA.BRAM_RES_ADDR - RBA) >> 2)];
    if (ifA.BRAM_GOLD_EN) ifA.BRAM_GOLD_DOUT <= goldA[9'((ifA.BRAM_GOLD_ADDR - GBA) >> 2)];
  end

  // Two-cycle-latency BRAM pair (array read + output register) for instance B.
  always @(posedge clk) begin
    if (ifB.BRAM_RES_EN)  qRB <= resB[9'((ifB.BRAM_RES_ADDR - RBB) >> 2)];
    if (ifB.BRAM_GOLD_EN) qGB <= goldB[9'((ifB.BRAM_GOLD_ADDR - GBB) >> 2)];
    ifB.BRAM_RES_DOUT  <= qRB;
    ifB.BRAM_GOLD_DOUT <= qGB;
  end

  int vec = 0;
  int mis = 0;
  exp_t sbq[$];
  int          logq_idx[$];
  logic [31:0] logq_got[$];

  function automatic int g_err(input int sel);  return sel ? int'(errB) : int'(errA); endfunction
  function automatic int g_idx(input int sel);  return sel ? int'(idxB) : int'(idxA); endfunction
  function automatic logic [31:0] g_got(input int sel); return sel ? gotB : gotA; endfunction
  function automatic logic [31:0] g_exp(input int sel); return sel ? expB : expA; endfunction
  function automatic logic g_done(input int sel); return sel ? doneB : doneA; endfunction
  function automatic logic g_busy(input int sel); return sel ? busyB : busyA; endfunction
  function automatic logic g_pass(input int sel); return sel ? passB : passA; endfunction

  // Reference result of a run over the current bench memories.
  function automatic exp_t model(input int sel);
    exp_t e;
    int   cnt, first, maxc;
    logic [31:0] r, g;
    cnt = 0; first = -1; maxc = sel ? 15 : 65535;
    e.got = '0; e.exp = '0;
    for (int i = 0; i < N; i++) begin
      r = sel ? resB[i] : resA[i];
      g = sel ? goldB[i] : goldA[i];
      if (r != g) begin
        if (cnt < maxc) cnt++;
        if (first < 0) begin first = i; e.got = r; e.exp = g; end
      end
    end
    e.err  = cnt;
    e.idx  = (first < 0) ? 'hFFFF : first;
    e.pass = (cnt == 0);
    e.lat  = N + (sel ? 2 : 1) + 1;
    return e;
  endfunction

  task automatic init_mem(input int sel);
    logic [31:0] g;
    for (int i = 0; i < 512; i++) begin
      g = $urandom;
      if (sel != 0) begin goldB[i] = g; resB[i] = g; end
      else begin goldA[i] = g; resA[i] = g; end
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) startB = v; else startA = v;
  endtask

  // Launch a run and follow it to done (or abort); gathers observations only.
  task automatic run(input int sel, input int extra_at, input int abort_at,
                     output int lat, output int en_cnt, output int addr_bad,
                     output logic busy0, output logic done0, output int err0);
    logic [31:0] rb, gb, ra, ga;
    logic re, ge;
    rb = sel ? RBB : RBA;
    gb = sel ? GBB : GBA;
    en_cnt = 0; addr_bad = 0; lat = -1;
    @(negedge clk); set_start(sel, 1'b1);
    @(posedge clk); #1; set_start(sel, 1'b0);
    busy0 = g_busy(sel); done0 = g_done(sel); err0 = g_err(sel);
    for (int k = 0; k < 400; k++) begin
      if (g_done(sel)) begin lat = k; break; end
      if (abort_at == k) begin rst = 1'b0; break; end
      re = sel ? ifB.BRAM_RES_EN : ifA.BRAM_RES_EN;
      ge = sel ? ifB.BRAM_GOLD_EN : ifA.BRAM_GOLD_EN;
      ra = sel ? ifB.BRAM_RES_ADDR : ifA.BRAM_RES_ADDR;
      ga = sel ? ifB.BRAM_GOLD_ADDR : ifA.BRAM_GOLD_ADDR;
      if (re != ge) addr_bad++;
      if (re) begin
        if (ra != rb + 32'(en_cnt * 4)) addr_bad++;
        if (ga != gb + 32'(en_cnt * 4)) addr_bad++;
        en_cnt++;
      end
      @(posedge clk); #1;
      set_start(sel, (k + 1) == extra_at);
    end
    set_start(sel, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; startA = 0; startB = 0; log_readyA = 1; log_readyB = 1;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (busyA !== 1'b0) begin mis++; $display("FAIL reset_busy got %b want 0", busyA); end
    vec++; if (doneA !== 1'b0) begin mis++; $display("FAIL reset_done got %b want 0", doneA); end
    vec++; if (passA !== 1'b0) begin mis++; $display("FAIL reset_pass got %b want 0", passA); end
    vec++; if (errA !== 16'd0) begin mis++; $display("FAIL reset_err got %0h want 0", errA); end
    vec++; if (idxA !== 16'hFFFF) begin mis++; $display("FAIL reset_idx got %0h want FFFF", idxA); end
    vec++; if (gotA !== 32'd0 || expA !== 32'd0) begin mis++; $display("FAIL reset_gotexp got %0h/%0h want 0/0", gotA, expA); end
    vec++; if (ifA.BRAM_RES_EN !== 1'b0 || ifA.BRAM_GOLD_EN !== 1'b0) begin mis++; $display("FAIL reset_en got %b%b want 00", ifA.BRAM_RES_EN, ifA.BRAM_GOLD_EN); end
    vec++; if (ifA.BRAM_RES_ADDR !== 32'd0 || ifA.BRAM_GOLD_ADDR !== 32'd0) begin mis++; $display("FAIL reset_addr got %0h/%0h want 0/0", ifA.BRAM_RES_ADDR, ifA.BRAM_GOLD_ADDR); end
    vec++; if (ifA.BRAM_RES_WE !== 4'd0 || ifA.BRAM_GOLD_WE !== 4'd0) begin mis++; $display("FAIL reset_we got %0h/%0h want 0/0", ifA.BRAM_RES_WE, ifA.BRAM_GOLD_WE); end
    vec++; if (ifA.BRAM_RES_DIN !== 32'd0 || ifA.BRAM_GOLD_DIN !== 32'd0) begin mis++; $display("FAIL reset_din got %0h/%0h want 0/0", ifA.BRAM_RES_DIN, ifA.BRAM_GOLD_DIN); end
    vec++; if (log_validA !== 1'b0) begin mis++; $display("FAIL reset_logv got %b want 0", log_validA); end
    vec++; if (busyB !== 1'b0 || errB !== 4'd0 || idxB !== 16'hFFFF) begin mis++; $display("FAIL reset_B got %b/%0h/%0h want 0/0/FFFF", busyB, errB, idxB); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_match();
    exp_t e; int lat, enc, ab, e0; logic b0, d0;
    init_mem(0);
    sbq.push_back(model(0));
    run(0, -1, -1, lat, enc, ab, b0, d0, e0);
    e = sbq.pop_front();
    vec++; if (b0 !== 1'b1) begin mis++; $display("FAIL match_busy got %b want 1", b0); end
    vec++; if (lat != e.lat) begin mis++; $display("FAIL match_latency got %0d want %0d", lat, e.lat); end
    vec++; if (passA !== e.pass) begin mis++; $display("FAIL match_pass got %b want %b", passA, e.pass); end
    vec++; if (int'(errA) != e.err) begin mis++; $display("FAIL match_err got %0d want %0d", errA, e.err); end
    vec++; if (int'(idxA) != e.idx) begin mis++; $display("FAIL match_idx got %0h want %0h", idxA, e.idx); end
    vec++; if (enc != N) begin mis++; $display("FAIL match_reads got %0d want %0d", enc, N); end
    vec++; if (ab != 0) begin mis++; $display("FAIL match_addr got %0d bad want 0", ab); end
    vec++; if (busyA !== 1'b0) begin mis++; $display("FAIL match_busy_done got %b want 0", busyA); end
  endtask

  task automatic test_single_mismatch();
    exp_t e; int lat, enc, ab, e0; logic b0, d0;
    init_mem(0);
    goldA[17] = 32'h0000_0A3C;
    resA[17]  = 32'hDEAD_BEEF;
    sbq.push_back(model(0));
    run(0, -1, -1, lat, enc, ab, b0, d0, e0);
    e = sbq.pop_front();
    vec++; if (lat != e.lat) begin mis++; $display("FAIL single_latency got %0d want %0d", lat, e.lat); end
    vec++; if (passA !== e.pass) begin mis++; $display("FAIL single_pass got %b want %b", passA, e.pass); end
    vec++; if (int'(errA) != e.err) begin mis++; $display("FAIL single_err got %0d want %0d", errA, e.err); end
    vec++; if (int'(idxA) != e.idx) begin mis++; $display("FAIL single_idx got %0d want %0d", idxA, e.idx); end
    vec++; if (gotA !== e.got) begin mis++; $display("FAIL single_got got %0h want %0h", gotA, e.got); end
    vec++; if (expA !== e.exp) begin mis++; $display("FAIL single_exp got %0h want %0h", expA, e.exp); end
`ifndef MISMATCH_LOG_EN
    vec++; if (log_validA !== 1'b0 || log_idxA !== 16'd0 || log_gotA !== 32'd0) begin mis++; $display("FAIL nolog_outputs got %b/%0h/%0h want 0/0/0", log_validA, log_idxA, log_gotA); end
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat, enc, ab, e0; logic b0, d0;
    init_mem(0);
    sbq.push_back(model(0));
    run(0, -1, -1, lat, enc, ab, b0, d0, e0);
    e = sbq.pop_front();
    vec++; if (d0 !== 1'b0) begin mis++; $display("FAIL b2b_done_drop got %b want 0", d0); end
    vec++; if (b0 !== 1'b1) begin mis++; $display("FAIL b2b_busy got %b want 1", b0); end
    vec++; if (e0 != 0) begin mis++; $display("FAIL b2b_err_clear got %0d want 0", e0); end
    vec++; if (lat != e.lat) begin mis++; $display("FAIL b2b_latency got %0d want %0d", lat, e.lat); end
    vec++; if (passA !== e.pass || int'(errA) != e.err) begin mis++; $display("FAIL b2b_result got %b/%0d want %b/%0d", passA, errA, e.pass, e.err); end
  endtask

  task automatic test_start_while_busy();
    exp_t e; int lat, enc, ab, e0; logic b0, d0;
    init_mem(0);
    resA[200] = ~goldA[200];
    for (int r = 0; r < 2; r++) begin
      sbq.push_back(model(0));
      run(0, (r == 0) ? 50 : 295, -1, lat, enc, ab, b0, d0, e0);
      e = sbq.pop_front();
      vec++; if (lat != e.lat) begin mis++; $display("FAIL busy_start_latency%0d got %0d want %0d", r, lat, e.lat); end
      vec++; if (enc != N) begin mis++; $display("FAIL busy_start_reads%0d got %0d want %0d", r, enc, N); end
      vec++; if (int'(errA) != e.err || int'(idxA) != e.idx) begin mis++; $display("FAIL busy_start_result%0d got %0d/%0d want %0d/%0d", r, errA, idxA, e.err, e.idx); end
    end
  endtask

  task automatic test_rdlat2_multi();
    exp_t e; int lat, enc, ab, e0; logic b0, d0;
    init_mem(1);
    resB[5]   = goldB[5] ^ 32'h0000_0001;
    resB[100] = goldB[100] ^ 32'h8000_0000;
    resB[293] = goldB[293] ^ 32'h0F0F_0000;
    sbq.push_back(model(1));
    run(1, -1, -1, lat, enc, ab, b0, d0, e0);
    e = sbq.pop_front();
    vec++; if (lat != e.lat) begin mis++; $display("FAIL rdlat2_latency got %0d want %0d", lat, e.lat); end
    vec++; if (g_err(1) != e.err) begin mis++; $display("FAIL rdlat2_err got %0d want %0d", g_err(1), e.err); end
    vec++; if (g_idx(1) != e.idx) begin mis++; $display("FAIL rdlat2_idx got %0d want %0d", g_idx(1), e.idx); end
    vec++; if (g_got(1) !== e.got || g_exp(1) !== e.exp) begin mis++; $display("FAIL rdlat2_gotexp got %0h/%0h want %0h/%0h", g_got(1), g_exp(1), e.got, e.exp); end
    vec++; if (g_pass(1) !== e.pass) begin mis++; $display("FAIL rdlat2_pass got %b want %b", g_pass(1), e.pass); end
    vec++; if (enc != N || ab != 0) begin mis++; $display("FAIL rdlat2_addr got %0d reads %0d bad want %0d/0", enc, ab, N); end
  endtask

  task automatic test_saturate();
    exp_t e; int lat, enc, ab, e0; logic b0, d0;
    init_mem(1);
    for (int i = 0; i < N; i++) resB[i] = ~goldB[i];
    sbq.push_back(model(1));
    run(1, -1, -1, lat, enc, ab, b0, d0, e0);
    e = sbq.pop_front();
    vec++; if (g_err(1) != e.err) begin mis++; $display("FAIL sat_err got %0d want %0d", g_err(1), e.err); end
    vec++; if (g_pass(1) !== e.pass) begin mis++; $display("FAIL sat_pass got %b want %b", g_pass(1), e.pass); end
    vec++; if (g_idx(1) != e.idx || g_got(1) !== e.got) begin mis++; $display("FAIL sat_first got %0d/%0h want %0d/%0h", g_idx(1), g_got(1), e.idx, e.got); end
    vec++; if (lat != e.lat) begin mis++; $display("FAIL sat_latency got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_reset_midrun();
    exp_t e; int lat, enc, ab, e0; logic b0, d0;
    init_mem(0);
    resA[3] = goldA[3] + 32'd1;
    run(0, -1, 100, lat, enc, ab, b0, d0, e0);
    #1;
    vec++; if (busyA !== 1'b0 || doneA !== 1'b0 || passA !== 1'b0) begin mis++; $display("FAIL abort_flags got %b%b%b want 000", busyA, doneA, passA); end
    vec++; if (errA !== 16'd0 || idxA !== 16'hFFFF) begin mis++; $display("FAIL abort_err got %0h/%0h want 0/FFFF", errA, idxA); end
    vec++; if (gotA !== 32'd0 || expA !== 32'd0) begin mis++; $display("FAIL abort_gotexp got %0h/%0h want 0/0", gotA, expA); end
    vec++; if (ifA.BRAM_RES_EN !== 1'b0 || ifA.BRAM_RES_ADDR !== 32'd0 || ifA.BRAM_GOLD_ADDR !== 32'd0) begin mis++; $display("FAIL abort_bus got %b/%0h/%0h want 0/0/0", ifA.BRAM_RES_EN, ifA.BRAM_RES_ADDR, ifA.BRAM_GOLD_ADDR); end
    repeat (3) @(posedge clk);
    #1;
    vec++; if (doneA !== 1'b0) begin mis++; $display("FAIL abort_no_done got %b want 0", doneA); end
    @(negedge clk); rst = 1'b1;
    sbq.push_back(model(0));
    run(0, -1, -1, lat, enc, ab, b0, d0, e0);
    e = sbq.pop_front();
    vec++; if (lat != e.lat || enc != N) begin mis++; $display("FAIL rerun_latency got %0d/%0d want %0d/%0d", lat, enc, e.lat, N); end
    vec++; if (int'(errA) != e.err || int'(idxA) != e.idx) begin mis++; $display("FAIL rerun_result got %0d/%0d want %0d/%0d", errA, idxA, e.err, e.idx); end
  endtask

`ifdef MISMATCH_LOG_EN
  task automatic test_log();
    exp_t e; int lat, enc, ab, e0; logic b0, d0;
    init_mem(0);
    log_readyA = 1'b0;
    for (int j = 0; j < 10; j++) begin
      resA[10*j+1] = goldA[10*j+1] ^ 32'h0000_0100;
      if (j < 8) begin logq_idx.push_back(10*j+1); logq_got.push_back(resA[10*j+1]); end
    end
    sbq.push_back(model(0));
    run(0, -1, -1, lat, enc, ab, b0, d0, e0);
    e = sbq.pop_front();
    vec++; if (int'(errA) != e.err) begin mis++; $display("FAIL log_err got %0d want %0d", errA, e.err); end
    for (int j = 0; j < 8; j++) begin
      vec++; if (log_validA !== 1'b1) begin mis++; $display("FAIL log_valid%0d got %b want 1", j, log_validA); end
      vec++; if (int'(log_idxA) != logq_idx[0] || log_gotA !== logq_got[0]) begin mis++; $display("FAIL log_entry%0d got %0d/%0h want %0d/%0h", j, log_idxA, log_gotA, logq_idx[0], logq_got[0]); end
      void'(logq_idx.pop_front()); void'(logq_got.pop_front());
      log_readyA = 1'b1;
      @(posedge clk); #1;
      log_readyA = 1'b0;
    end
    vec++; if (log_validA !== 1'b0) begin mis++; $display("FAIL log_empty got %b want 0", log_validA); end
    log_readyA = 1'b1;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_match();
    test_single_mismatch();
    test_back_to_back();
    test_start_while_busy();
    test_rdlat2_multi();
    test_saturate();
    test_reset_midrun();
`ifdef MISMATCH_LOG_EN
    test_log();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
